// File: rtl/am_removal_pkg.sv
// Shared definitions for the alignment-marker removal stage: FSM encoding, default
// geometry and width helpers.
package am_removal_pkg;

  localparam int DEF_NB_DATA   = 66;
  localparam int DEF_N_LANES   = 20;
  localparam int DEF_AM_PERIOD = 16383;

  // One AM per PCS lane makes up a group; a period spans AM_PERIOD data blocks per lane.
  localparam int AM_GROUP_LEN  = DEF_N_LANES;
  localparam int EXPECTED_DATA = DEF_N_LANES * DEF_AM_PERIOD;

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_IN_GROUP = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  // Bits needed to hold the values 0..max_value inclusive.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/am_period_counter.sv
// Data-block counter between AM groups: clears on group completion, saturates at
// LIMIT, and flags both the limit and the empty (just-cleared) condition.
module am_period_counter #(
  parameter int LIMIT  = 32,
  parameter int NB_CNT = 6
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_at_limit,
  output logic o_empty
);

  localparam logic [NB_CNT-1:0] LIMIT_C = NB_CNT'(LIMIT);

  logic [NB_CNT-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_inc && (cnt != LIMIT_C)) begin
      cnt <= cnt + NB_CNT'(1);
    end
  end

  assign o_at_limit = (cnt == LIMIT_C);
  assign o_empty    = (cnt == '0);

endmodule

// File: rtl/am_removal.sv
// Alignment-marker removal: drops AM blocks, checks AM-group structure and forwards data.
// Optional AM spacing check enabled by defining AM_REMOVAL_PERIOD_CHECK_EN.
module am_removal
  import am_removal_pkg::*;
#(
  parameter int NB_DATA   = DEF_NB_DATA,
  parameter int N_LANES   = AM_GROUP_LEN,
  parameter int AM_PERIOD = DEF_AM_PERIOD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tag,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_locked,
  output logic               o_group_done,
  output logic               o_group_error,
  output logic               o_period_error
);

  localparam int NB_AM_CNT = cnt_width(N_LANES);
  localparam logic [NB_AM_CNT-1:0] LAST_AM = NB_AM_CNT'(N_LANES - 1);

  logic acc;
  assign acc = i_enable && i_valid;

  state_t               state, state_next;
  logic [NB_AM_CNT-1:0] am_cnt, am_cnt_next;
  logic [NB_DATA-1:0]   data_next;
  logic                 valid_next, locked_next, done_next, gerr_next, perr_next;

`ifdef AM_REMOVAL_PERIOD_CHECK_EN
  localparam int NB_PERIOD_CNT = cnt_width(N_LANES * AM_PERIOD);

  logic cnt_inc, cnt_clear, at_limit, cnt_empty;

  am_period_counter #(
    .LIMIT  (N_LANES * AM_PERIOD),
    .NB_CNT (NB_PERIOD_CNT)
  ) u_period_counter (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_inc      (cnt_inc),
    .i_clear    (cnt_clear),
    .o_at_limit (at_limit),
    .o_empty    (cnt_empty)
  );
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    am_cnt_next = am_cnt;
    data_next   = o_data;
    valid_next  = 1'b0;
    locked_next = o_locked;
    done_next   = 1'b0;
    gerr_next   = 1'b0;
    perr_next   = 1'b0;
`ifdef AM_REMOVAL_PERIOD_CHECK_EN
    cnt_inc     = 1'b0;
    cnt_clear   = 1'b0;
`endif
    if (acc) begin
      unique case (state)
        ST_SYNC: begin
          if (i_tag) begin
            state_next  = ST_IN_GROUP;
            am_cnt_next = NB_AM_CNT'(1);
          end
        end
        ST_IN_GROUP: begin
          if (i_tag) begin
            if (am_cnt == LAST_AM) begin
              state_next  = ST_DATA;
              am_cnt_next = '0;
              done_next   = 1'b1;
              locked_next = 1'b1;
`ifdef AM_REMOVAL_PERIOD_CHECK_EN
              cnt_clear   = 1'b1;
`endif
            end else begin
              am_cnt_next = am_cnt + NB_AM_CNT'(1);
            end
          end else begin
            state_next  = ST_SYNC;
            am_cnt_next = '0;
            gerr_next   = 1'b1;
            locked_next = 1'b0;
          end
        end
        ST_DATA: begin
          if (i_tag) begin
            state_next  = ST_IN_GROUP;
            am_cnt_next = NB_AM_CNT'(1);
`ifdef AM_REMOVAL_PERIOD_CHECK_EN
            // An AM right after a completed group just opens the next group.
            if (!at_limit && !cnt_empty) begin
              perr_next   = 1'b1;
              locked_next = 1'b0;
            end
`endif
          end else begin
`ifdef AM_REMOVAL_PERIOD_CHECK_EN
            if (at_limit) begin
              state_next  = ST_SYNC;
              perr_next   = 1'b1;
              locked_next = 1'b0;
            end else begin
              data_next  = i_data;
              valid_next = 1'b1;
              cnt_inc    = 1'b1;
            end
`else
            data_next  = i_data;
            valid_next = 1'b1;
`endif
          end
        end
        default: state_next = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= ST_SYNC;
      am_cnt         <= '0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_locked       <= 1'b0;
      o_group_done   <= 1'b0;
      o_group_error  <= 1'b0;
      o_period_error <= 1'b0;
    end else begin
      state          <= state_next;
      am_cnt         <= am_cnt_next;
      o_data         <= data_next;
      o_valid        <= valid_next;
      o_locked       <= locked_next;
      o_group_done   <= done_next;
      o_group_error  <= gerr_next;
      o_period_error <= perr_next;
    end
  end

endmodule

// File: tb/tb_am_removal.sv
// Self-checking bench for am_removal (N_LANES=4, AM_PERIOD=8) against a behavioural
// model of AM grouping, data forwarding and optional spacing checks.
module tb_am_removal;

  localparam int NB  = 66;
  localparam int NL  = 4;
  localparam int AP  = 8;
  localparam int EXP = NL * AP;
`ifdef AM_REMOVAL_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          i_clock, i_reset, i_enable, i_valid, i_tag;
  logic [NB-1:0] i_data;
  logic [NB-1:0] o_data;
  logic          o_valid, o_locked, o_group_done, o_group_error, o_period_error;

  am_removal #(.NB_DATA(NB), .N_LANES(NL), .AM_PERIOD(AP)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_tag          (i_tag),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_locked       (o_locked),
    .o_group_done   (o_group_done),
    .o_group_error  (o_group_error),
    .o_period_error (o_period_error)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fwd    = 0;

  // Behavioural model: hunting for a group, position inside a group, or counting data.
  bit            m_hunting;
  int            m_pos;
  int            m_seen;
  bit            m_locked;
  logic [NB-1:0] m_data;
  bit            e_valid, e_done, e_gerr, e_perr;

  task automatic check(input string name, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
      $error("check %s", name);
    end
  endtask

  task automatic model_reset();
    m_hunting = 1'b1;
    m_pos     = 0;
    m_seen    = 0;
    m_locked  = 1'b0;
    m_data    = '0;
    e_valid   = 1'b0;
    e_done    = 1'b0;
    e_gerr    = 1'b0;
    e_perr    = 1'b0;
  endtask

  task automatic model_accept(input bit tag, input logic [NB-1:0] data);
    bit in_data;
    in_data = !m_hunting && (m_pos == 0);
    if (tag) begin
      if (PCHK && in_data && m_seen != 0 && m_seen != EXP) begin
        e_perr   = 1'b1;
        m_locked = 1'b0;
      end
      m_hunting = 1'b0;
      m_pos++;
      if (m_pos == NL) begin
        e_done   = 1'b1;
        m_locked = 1'b1;
        m_pos    = 0;
        m_seen   = 0;
      end
    end else if (m_pos > 0) begin
      e_gerr    = 1'b1;
      m_locked  = 1'b0;
      m_hunting = 1'b1;
      m_pos     = 0;
    end else if (!m_hunting) begin
      if (PCHK && m_seen == EXP) begin
        e_perr    = 1'b1;
        m_locked  = 1'b0;
        m_hunting = 1'b1;
      end else begin
        e_valid = 1'b1;
        m_data  = data;
        if (m_seen < EXP) m_seen++;
      end
    end
  endtask

  function automatic logic [NB-1:0] rand_block();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[NB-1:0];
  endfunction

  // One clock: apply inputs, advance, update the model, compare every output.
  task automatic drive(input bit rst, input bit en, input bit vld, input bit tag, input logic [NB-1:0] data);
    i_reset  = rst;
    i_enable = en;
    i_valid  = vld;
    i_tag    = tag;
    i_data   = data;
    @(posedge i_clock);
    #1;
    if (rst) model_reset();
    else begin
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_gerr  = 1'b0;
      e_perr  = 1'b0;
      if (en && vld) model_accept(tag, data);
    end
    if (o_valid === 1'b1) n_fwd++;
    check("o_valid",        NB'(o_valid),        NB'(e_valid));
    check("o_data",         o_data,              m_data);
    check("o_locked",       NB'(o_locked),       NB'(m_locked));
    check("o_group_done",   NB'(o_group_done),   NB'(e_done));
    check("o_group_error",  NB'(o_group_error),  NB'(e_gerr));
    check("o_period_error", NB'(o_period_error), NB'(e_perr));
  endtask

  task automatic send_am();
    drive(1'b0, 1'b1, 1'b1, 1'b1, rand_block());
  endtask

  task automatic send_data();
    drive(1'b0, 1'b1, 1'b1, 1'b0, rand_block());
  endtask

  task automatic reset_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, rand_block());
  endtask

  initial begin
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_tag    = 1'b0;
    i_data   = '0;
    model_reset();

    // Reset state and data dropped while hunting.
    reset_cycle();
    reset_cycle();
    send_data();

    // Scenario 1: group, one full period of data, group.
    n_fwd = 0;
    repeat (NL) send_am();
    repeat (EXP) send_data();
    repeat (NL) send_am();
    check("s1_forwarded", NB'(n_fwd), NB'(EXP));

    // Scenario 2: broken group then a clean one.
    reset_cycle();
    repeat (2) send_am();
    send_data();
    repeat (NL) send_am();

    // Scenario 3: AM arrives one data block early, then relock.
    repeat (EXP - 1) send_data();
    repeat (NL) send_am();

    // Scenario 4: one data block too many, then relock.
    repeat (EXP + 1) send_data();
    repeat (NL) send_am();

    // More than N_LANES consecutive AMs: two back-to-back groups, then data.
    repeat (2 * NL) send_am();
    repeat (3) send_data();

    // Scenario 5: scenario 1 with random gaps and a 5-cycle enable-low window.
    reset_cycle();
    n_fwd = 0;
    for (int k = 0; k < 2 * NL + EXP; k++) begin
      while ($urandom_range(1, 0) == 1) drive(1'b0, 1'b1, 1'b0, $urandom_range(1, 0) == 1, rand_block());
      if (k == NL + EXP / 2) begin
        for (int g = 0; g < 5; g++) drive(1'b0, 1'b0, 1'b1, $urandom_range(1, 0) == 1, rand_block());
      end
      drive(1'b0, 1'b1, 1'b1, (k < NL) || (k >= NL + EXP), rand_block());
    end
    check("s5_forwarded", NB'(n_fwd), NB'(EXP));

    // Scenario 6: reset in the middle of a group, then lock normally.
    repeat (2) send_am();
    reset_cycle();
    repeat (NL) send_am();
    repeat (2) send_data();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
